dcache_wb_dm: RTL

Direct-mapped, write-back, write-allocate data cache between the single-cycle MIPS datapath and the 20-cycle `main_memory` DRAM model. It serves word reads and writes in zero wait states on a hit. On a miss it stalls the core through `cpu_ready`. It fetches 128-bit blocks from DRAM and writes back a dirty victim in the same DRAM transaction.

---
 rtl/dcache_wb_dm.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/dcache_wb_dm.sv
// dcache_wb_dm
// Direct-mapped, write-back, write-allocate data cache that sits between the
// single-cycle core and the block-oriented DRAM model.
//   Hits complete in the request cycle: cpu_ready=1, and cpu_rdata is read
//   combinationally from the array. A store commits at the clock edge.
//   Misses stall the core. One DRAM transaction is issued per miss. It fetches
//   the 128-bit block and, when the victim is dirty, carries the victim
//   writeback too.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   cpu_read/cpu_write   load/store request (write wins when both are high)
//   cpu_addr/cpu_wdata   byte address (bits [1:0] ignored) and store data
//   cpu_rdata/cpu_ready  load data and access-complete / idle indication
//   mem_req              one-cycle transaction start pulse
//   mem_read/mem_raddr   fill request and block address
//   mem_rdata            fill block from DRAM
//   mem_write/mem_waddr  victim writeback request and block address
//   mem_wdata            victim block
//   mem_ready            DRAM idle/done
//   hit_count/miss_count first-attempt hit and miss counters (wrap at 2^32)
module dcache_wb_dm #(
    parameter int LINES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_read,
    input  logic         cpu_write,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic         mem_req,
    output logic         mem_read,
    output logic [31:0]  mem_raddr,
    input  logic [127:0] mem_rdata,
    output logic         mem_write,
    output logic [31:0]  mem_waddr,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 32 - 4 - IDX;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t            state_r;
    logic [LINES-1:0]  valid_r;
    logic [LINES-1:0]  dirty_r;
    logic [TAGW-1:0]   tag_r  [LINES];
    logic [127:0]      data_r [LINES];
    logic              replay_r;

    logic [IDX-1:0]    idx_s;
    logic [TAGW-1:0]   tag_s;
    logic [1:0]        off_s;
    logic              req_s;
    logic              hit_s;
    logic              victim_dirty_s;
    logic              hit_write_s;
    logic              fill_s;
    logic [127:0]      line_s;
    logic [127:0]      merged_s;
    logic              unused_addr_s;

    // Pick one 32-bit word lane out of a block.
    function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] off);
        case (off)
            2'd0:    word_sel = blk[31:0];
            2'd1:    word_sel = blk[63:32];
            2'd2:    word_sel = blk[95:64];
            2'd3:    word_sel = blk[127:96];
            default: word_sel = blk[31:0];
        endcase
    endfunction

    // Replace one 32-bit word lane of a block.
    function automatic logic [127:0] word_merge(input logic [127:0] blk, input logic [1:0] off,
                                                input logic [31:0] w);
        word_merge = blk;
        case (off)
            2'd0:    word_merge[31:0]   = w;
            2'd1:    word_merge[63:32]  = w;
            2'd2:    word_merge[95:64]  = w;
            2'd3:    word_merge[127:96] = w;
            default: word_merge = blk;
        endcase
    endfunction

    assign unused_addr_s = ^cpu_addr[1:0];

    // Address decode, hit detection and the zero-wait-state CPU response.
    always_comb begin
        idx_s          = cpu_addr[4+IDX-1:4];
        tag_s          = cpu_addr[31:4+IDX];
        off_s          = cpu_addr[3:2];
        req_s          = cpu_read | cpu_write;
        line_s         = data_r[idx_s];
        hit_s          = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
        victim_dirty_s = valid_r[idx_s] & dirty_r[idx_s];
        merged_s       = word_merge(line_s, off_s, cpu_wdata);
        cpu_rdata      = word_sel(line_s, off_s);
        hit_write_s    = (state_r == ST_IDLE) && req_s && hit_s && cpu_write;
        fill_s         = (state_r == ST_WAIT_DONE) && mem_ready;
        if (state_r == ST_IDLE) begin
            cpu_ready = !req_s || hit_s;
        end else begin
            cpu_ready = 1'b0;
        end
    end

    // Tag and data storage. There is no reset here because valid_r qualifies
    // every entry. The fill indexes with the held cpu_addr, which the core
    // keeps stable for the whole miss.
    always_ff @(posedge clk) begin
        if (!reset && hit_write_s) begin
            data_r[idx_s] <= merged_s;
        end else if (!reset && fill_s) begin
            data_r[idx_s] <= mem_rdata;
            tag_r[idx_s]  <= tag_s;
        end
    end

    // Miss FSM with line status bits, counters and registered DRAM request outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            valid_r    <= '0;
            dirty_r    <= '0;
            replay_r   <= 1'b0;
            mem_req    <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_raddr  <= 32'd0;
            mem_waddr  <= 32'd0;
            mem_wdata  <= 128'd0;
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mem_req <= 1'b0;
                    if (req_s && hit_s) begin
                        if (cpu_write) begin
                            dirty_r[idx_s] <= 1'b1;
                        end
                        // The access that follows a fill completes a miss
                        // that has already been counted. It is not a hit.
                        if (!replay_r) begin
                            hit_count <= hit_count + 32'd1;
                        end
                        replay_r <= 1'b0;
                    end else if (req_s) begin
                        miss_count <= miss_count + 32'd1;
                        mem_req    <= 1'b1;
                        mem_read   <= 1'b1;
                        mem_raddr  <= {cpu_addr[31:4], 4'b0000};
                        if (victim_dirty_s) begin
                            mem_write <= 1'b1;
                            mem_waddr <= {tag_r[idx_s], idx_s, 4'b0000};
                            mem_wdata <= line_s;
                        end else begin
                            mem_write <= 1'b0;
                            mem_waddr <= 32'd0;
                            mem_wdata <= 128'd0;
                        end
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_req <= 1'b0;
                    state_r <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    // Wait for DRAM to acknowledge by dropping ready.
                    if (!mem_ready) begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (mem_ready) begin
                        valid_r[idx_s] <= 1'b1;
                        dirty_r[idx_s] <= 1'b0;
                        replay_r       <= 1'b1;
                        mem_read       <= 1'b0;
                        mem_write      <= 1'b0;
                        mem_raddr      <= 32'd0;
                        mem_waddr      <= 32'd0;
                        mem_wdata      <= 128'd0;
                        state_r        <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
